vote_ballot_encoder: RTL and testbench
======================================

// Module: vote_ballot_encoder
// PURPOSE
//   Input-side unit of the e-voting machine, upstream of the counter/7-seg display path.
//   Debounces candidate push-buttons and enforces one vote per voter via an officer arm/open handshake.
//   Encodes the selected button to a candidate index and keeps saturating per-candidate tallies.
//   Tallies feed the display path; the block runs on the same free-running CLK from the clock generator.
// PARAMETERS
//   NUM_CAND   3     number of candidate buttons/tallies (2..4)
//   CNT_W      10    tally width; matches the display counter width
//   MAX_COUNT  999   tally saturation value (3-digit 7-seg limit); must be < 2**CNT_W
//   DEB_CYC    4     consecutive stable samples required to accept a button level (>=2)
// PORTS
//   CLK        in   1                system clock, rising edge
//   reset      in   1                asynchronous, active-low reset
//   open_ballot in  1                officer strobe: arms machine for exactly one vote
//   btn        in   NUM_CAND         raw candidate buttons, active-high, asynchronous to CLK
//   ready      out  1                1 = armed, waiting for a vote
//   vote_valid out  1                one-cycle pulse when a vote is recorded
//   vote_id    out  2                index of candidate voted; held until next vote
//   multi_err  out  1                one-cycle pulse: >1 button stable-pressed while armed
//   tally      out  NUM_CAND*CNT_W   packed tallies, candidate i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//   Reset (reset=0, async): state=LOCKED; all tallies=0; ready=0, vote_valid=0, multi_err=0, vote_id=0;
//     synchronisers and debounce counters cleared (debounced level 0).
//   Input path: each btn bit -> 2-flop synchroniser -> debounce counter. Debounced level changes only
//     after DEB_CYC consecutive samples at the new value; any mismatch restarts the count.
//     Latency raw edge -> debounced level = 2 + DEB_CYC cycles.
//   FSM states: LOCKED, ARMED, RECORD, WAIT_REL.
//     LOCKED : ready=0. open_ballot=1 and all debounced btns=0 -> ARMED.
//              open_ballot while any button held is ignored (stays LOCKED).
//     ARMED  : ready=1. Exactly one debounced btn=1 -> RECORD; latch its index.
//              >1 debounced btn=1 -> pulse multi_err for one cycle, no vote; stay ARMED, no re-pulse
//              until all buttons released. open_ballot in ARMED is ignored (no double arming).
//     RECORD : one cycle; vote_valid=1, vote_id=index, tally[index]+=1 unless already MAX_COUNT
//              (saturates, vote_valid still pulses). ready=0. -> WAIT_REL.
//     WAIT_REL: ready=0; when all debounced btns=0 -> LOCKED. Presses here never count.
//   Tally update lands in the same edge that vote_valid rises; only one tally changes per vote.
//   open_ballot sampled as a level each cycle; it may be held high for many cycles and still arms once.
//   Simultaneous open_ballot and a press in LOCKED: press wins, stays LOCKED (no arm).
//   reset asserted mid-vote (any state): immediate LOCKED, tallies cleared, no vote_valid emitted.
//   vote_id width fixed at 2; NUM_CAND > 4 is illegal.
// TESTING
//   Reset: reset=0 for 3 cycles then 1 -> all tallies 0, ready=0, no pulses for 20 cycles.
//   Single vote: open_ballot 1 cycle, btn=3'b010 held 10 cycles -> ready=1 until RECORD;
//     vote_valid pulse exactly 7 cycles after btn rise (DEB_CYC=4), vote_id=1, tally1=1, others 0.
//   Double vote: after above, press btn[1] again without open_ballot -> no vote_valid, tally1 stays 1.
//   Bounce: btn[0] toggles every cycle for 8 cycles, then stable high -> exactly one vote, tally0=1.
//   Multi-press: armed, btn=3'b101 -> single multi_err pulse, no tally change; release, press 3'b100
//     -> vote_id=2, tally2=1.
//   Saturation/reset: preload via 999 votes on candidate 0 -> 1000th vote pulses vote_valid,
//     tally0 stays 999; assert reset in WAIT_REL -> all tallies 0, state LOCKED.

Source files
------------

// File: rtl/vote_ballot_encoder.sv
// Ballot input unit: synchronises and debounces candidate buttons, enforces
// one vote per officer arming, and keeps saturating per-candidate tallies.
module vote_ballot_encoder #(
  parameter int NUM_CAND  = 3,
  parameter int CNT_W     = 10,
  parameter int MAX_COUNT = 999,
  parameter int DEB_CYC   = 4
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      open_ballot,
  input  logic [NUM_CAND-1:0]       btn,
  output logic                      ready,
  output logic                      vote_valid,
  output logic [1:0]                vote_id,
  output logic                      multi_err,
  output logic [NUM_CAND*CNT_W-1:0] tally
);

  // Counter only needs to reach DEB_CYC-1 before the level flips.
  localparam int DW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    ARMED    = 2'd1,
    RECORD   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [NUM_CAND-1:0] btn_p0, btn_p1;
  logic [NUM_CAND-1:0] deb_p2;
  logic [DW-1:0]       dcnt [NUM_CAND];
  logic [2:0]          n_press;
  logic [1:0]          sel_idx;
  logic                take_vote;
  logic                multi_hit;
  logic                multi_seen;

  // Stage p0/p1: two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
    end else begin
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
    end
  end

  // Stage p2: accept a new level only after DEB_CYC consecutive differing samples.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      deb_p2 <= '0;
      for (int i = 0; i < NUM_CAND; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (btn_p1[i] != deb_p2[i]) begin
          if (dcnt[i] == DW'(DEB_CYC - 1)) begin
            deb_p2[i] <= btn_p1[i];
            dcnt[i]   <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  // Count pressed buttons and pick the index of the (last) pressed one.
  always_comb begin
    n_press = 3'd0;
    sel_idx = 2'd0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (deb_p2[i]) begin
        n_press = n_press + 3'd1;
        sel_idx = 2'(i);
      end
    end
  end

  // Ballot state register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= LOCKED;
    else        state <= state_nx;
  end

  // Next state and per-state outputs; the vote is taken on the ARMED->RECORD edge
  // so the tally changes on the same edge vote_valid rises.
  always_comb begin
    state_nx   = state;
    ready      = 1'b0;
    vote_valid = 1'b0;
    take_vote  = 1'b0;
    multi_hit  = 1'b0;
    case (state)
      LOCKED: begin
        if (open_ballot && (n_press == 3'd0)) state_nx = ARMED;
      end
      ARMED: begin
        ready = 1'b1;
        if (n_press == 3'd1) begin
          state_nx  = RECORD;
          take_vote = 1'b1;
        end else if ((n_press > 3'd1) && !multi_seen) begin
          multi_hit = 1'b1;
        end
      end
      RECORD: begin
        vote_valid = 1'b1;
        state_nx   = WAIT_REL;
      end
      WAIT_REL: begin
        if (n_press == 3'd0) state_nx = LOCKED;
      end
      default: state_nx = LOCKED;
    endcase
  end

  // Vote capture, saturating tallies and the one-shot multi-press flag.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      tally      <= '0;
      vote_id    <= 2'd0;
      multi_err  <= 1'b0;
      multi_seen <= 1'b0;
    end else begin
      multi_err <= multi_hit;
      if (multi_hit)
        multi_seen <= 1'b1;
      else if (n_press == 3'd0)
        multi_seen <= 1'b0;
      if (take_vote) vote_id <= sel_idx;
      for (int i = 0; i < NUM_CAND; i++) begin
        if (take_vote && (sel_idx == 2'(i)) &&
            (tally[i*CNT_W +: CNT_W] != CNT_W'(MAX_COUNT)))
          tally[i*CNT_W +: CNT_W] <= tally[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vote_ballot_encoder.sv
// Randomised bench for vote_ballot_encoder against a transaction-level ballot model.
module tb_vote_ballot_encoder;

  localparam int NC   = 3;
  localparam int CW   = 10;
  localparam int MAXC = 999;

  logic             CLK = 1'b0;
  logic             reset;
  logic             open_ballot;
  logic [NC-1:0]    btn;
  logic             ready, vote_valid, multi_err;
  logic [1:0]       vote_id;
  logic [NC*CW-1:0] tally;

  int n_chk  = 0;
  int n_pass = 0;
  int vv_cnt = 0;
  int me_cnt = 0;
  logic [1:0] last_id = 2'd0;

  // Ballot model: tallies plus whether the machine is armed.
  int mtally [NC];
  bit armed;

  vote_ballot_encoder #(.NUM_CAND(NC), .CNT_W(CW), .MAX_COUNT(MAXC), .DEB_CYC(4)) dut (
    .CLK(CLK), .reset(reset), .open_ballot(open_ballot), .btn(btn),
    .ready(ready), .vote_valid(vote_valid), .vote_id(vote_id),
    .multi_err(multi_err), .tally(tally)
  );

  always #5 CLK = ~CLK;

  // Pulse monitor, sampled just after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (vote_valid) begin
      vv_cnt  = vv_cnt + 1;
      last_id = vote_id;
    end
    if (multi_err) me_cnt = me_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_tallies(input string tag);
    for (int i = 0; i < NC; i++)
      chk($sformatf("%s_tally%0d", tag, i), 32'(tally[i*CW +: CW]), 32'(mtally[i]));
  endtask

  task automatic do_open(input int len);
    open_ballot = 1'b1;
    tick(len);
    open_ballot = 1'b0;
    tick(2);
    armed = 1'b1;
    chk("open_ready", 32'(ready), 32'(armed));
  endtask

  task automatic do_press(input logic [NC-1:0] mask, input bit bounce, input bit open_mid);
    int vv0, me0, c;
    bit exp_vote, exp_multi;
    vv0 = vv_cnt;
    me0 = me_cnt;
    exp_vote  = armed && ($countones(mask) == 1);
    exp_multi = armed && ($countones(mask) > 1);
    c = 0;
    for (int i = 0; i < NC; i++) if (mask[i]) c = i;
    if (bounce) begin
      for (int k = 0; k < 8; k++) begin
        btn = (k % 2 == 0) ? mask : '0;
        tick(1);
      end
    end
    btn = mask;
    for (int k = 0; k < 12; k++) begin
      open_ballot = open_mid && (k == 8);
      tick(1);
    end
    open_ballot = 1'b0;
    btn = '0;
    tick(12);
    if (exp_vote) begin
      if (mtally[c] < MAXC) mtally[c] = mtally[c] + 1;
      armed = 1'b0;
    end
    chk("vote_pulses", 32'(vv_cnt - vv0), 32'(exp_vote));
    chk("multi_pulses", 32'(me_cnt - me0), 32'(exp_multi));
    if (exp_vote) chk("vote_id", 32'(last_id), 32'(c));
    chk("ready_after", 32'(ready), 32'(armed));
    chk_tallies("press");
  endtask

  initial begin
    int first, vv0, me0, r;
    bit seen;
    logic [NC-1:0] mm;
    reset = 1'b0;
    open_ballot = 1'b0;
    btn = '0;
    armed = 1'b0;
    for (int i = 0; i < NC; i++) mtally[i] = 0;

    // Reset and quiet period
    tick(3);
    reset = 1'b1;
    vv0 = vv_cnt;
    me0 = me_cnt;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_id", 32'(vote_id), 0);
    chk_tallies("rst");
    tick(20);
    chk("rst_quiet_vv", 32'(vv_cnt - vv0), 0);
    chk("rst_quiet_me", 32'(me_cnt - me0), 0);
    chk("rst_ready_late", 32'(ready), 0);

    // Single vote with latency measurement
    open_ballot = 1'b1;
    tick(1);
    open_ballot = 1'b0;
    btn = 3'b010;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 6) chk("ready_before_rec", 32'(ready), 1);
      if (vote_valid && first == 0) begin
        first = k;
        chk("tally_with_vv", 32'(tally[CW +: CW]), 1);
        chk("ready_in_rec", 32'(ready), 0);
      end
    end
    chk("vv_latency", 32'(first), 7);
    btn = '0;
    tick(12);
    mtally[1] = 1;
    armed = 1'b0;
    chk("single_id", 32'(vote_id), 1);
    chk_tallies("single");

    // Double vote attempt without arming
    do_press(3'b010, 1'b0, 1'b0);
    // Bouncing press
    do_open(1);
    do_press(3'b001, 1'b1, 1'b0);
    // Multi-press then valid press
    do_open(1);
    do_press(3'b101, 1'b0, 1'b0);
    do_press(3'b100, 1'b0, 1'b0);
    // Press held while officer opens: must not arm
    do_press(3'b001, 1'b0, 1'b1);

    // Randomised operations
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        do_open($urandom_range(1, 6));
      end else if (r < 8) begin
        mm = '0;
        mm[$urandom_range(0, NC - 1)] = 1'b1;
        do_press(mm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        do
          mm = NC'($urandom_range(1, (1 << NC) - 1));
        while ($countones(mm) < 2);
        do_press(mm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    // Saturate candidate 0, then one more vote
    while (mtally[0] < MAXC) begin
      do_open(1);
      do_press(3'b001, 1'b0, 1'b0);
    end
    do_open(1);
    do_press(3'b001, 1'b0, 1'b0);

    // Reset asserted while waiting for release
    do_open(1);
    btn = 3'b001;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (vote_valid) seen = 1'b1;
    end
    chk("wr_vote_seen", 32'(seen), 1);
    tick(1);
    chk("wr_ready", 32'(ready), 0);
    vv0 = vv_cnt;
    #2;
    reset = 1'b0;
    #2;
    for (int i = 0; i < NC; i++) mtally[i] = 0;
    armed = 1'b0;
    chk_tallies("wr_rst");
    chk("wr_rst_ready", 32'(ready), 0);
    chk("wr_rst_vv", 32'(vote_valid), 0);
    tick(2);
    btn = '0;
    tick(1);
    reset = 1'b1;
    tick(12);
    chk("wr_no_vv", 32'(vv_cnt - vv0), 0);
    chk("wr_locked", 32'(ready), 0);
    do_open(1);
    do_press(3'b010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
